// File: rtl/pixel_writer_pkg.sv
// Shared types for the pixel writer: fp24 colour encoding and FSM states.
package pixel_writer_pkg;

    localparam int unsigned FP24_W      = 24;
    localparam int unsigned FP24_EXP_W  = 7;
    localparam int unsigned FP24_MANT_W = 16;
    localparam int unsigned FP24_BIAS   = 63;

    typedef logic [FP24_W-1:0] fp24;

    typedef struct packed {
        fp24 r;
        fp24 g;
        fp24 b;
    } fp24_vec3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_RD0   = 3'd2,
        ST_RD1   = 3'd3,
        ST_BLEND = 3'd4,
        ST_WRITE = 3'd5
    } state_e;

endpackage

// File: rtl/fp24_to_u8.sv
// Combinational conversion of one fp24 channel to a clamped, truncated 8-bit value.
module fp24_to_u8
    import pixel_writer_pkg::*;
(
    input  fp24        val_i,
    output logic [7:0] u8_o
);

    logic                   sign_bit;
    logic [FP24_EXP_W-1:0]  exp_f;
    logic [FP24_MANT_W-1:0] mant_f;
    logic [2:0]             shamt;
    logic                   unused_mant;

    assign sign_bit    = val_i[FP24_W-1];
    assign exp_f       = val_i[FP24_W-2:FP24_MANT_W];
    assign mant_f      = val_i[FP24_MANT_W-1:0];
    assign unused_mant = ^mant_f[8:0];

    // Negative and tiny values flush to zero, values >= 1.0 clamp to full scale.
    always_comb begin
        u8_o  = 8'd0;
        shamt = 3'(7'(FP24_BIAS - 1) - exp_f);
        if (sign_bit) begin
            u8_o = 8'd0;
        end else if (exp_f >= 7'(FP24_BIAS)) begin
            u8_o = 8'hFF;
        end else if (exp_f < 7'(FP24_BIAS - 8)) begin
            u8_o = 8'd0;
        end else begin
            u8_o = {1'b1, mant_f[15:9]} >> shamt;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Converts finished ray colours to RGB888 and writes them to the framebuffer.
// Optional progressive accumulation (read-modify-write blend) with PIXEL_WRITER_ACCUM_EN.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int unsigned WIDTH     = 1280,
    parameter int unsigned HEIGHT    = 720,
    parameter int unsigned MAX_SHIFT = 4,
    parameter int unsigned ADDR_W    = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ray_done,
    input  fp24_vec3          pixel_color,
    input  logic [10:0]       pixel_h_in,
    input  logic [9:0]        pixel_v_in,
    output logic              in_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_wdata,
    output logic              fb_we,
    input  logic [23:0]       fb_rdata,
    output logic              frame_done,
    output logic [7:0]        frame_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_e            state_q, state_d;
    fp24_vec3          color_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              ready_q;
    logic              done_q, done_d;
    logic [7:0]        count_q, count_d;

    logic              accept;
    logic              in_range_in;
    logic [ADDR_W-1:0] addr_in;
    logic [7:0]        r8, g8, b8;

    assign accept      = (state_q == ST_IDLE) && ray_done;
    assign in_range_in = (32'(pixel_h_in) < WIDTH) && (32'(pixel_v_in) < HEIGHT);
    assign addr_in     = ADDR_W'(pixel_v_in) * ADDR_W'(WIDTH) + ADDR_W'(pixel_h_in);

    fp24_to_u8 u_conv_r (.val_i(color_q.r), .u8_o(r8));
    fp24_to_u8 u_conv_g (.val_i(color_q.g), .u8_o(g8));
    fp24_to_u8 u_conv_b (.val_i(color_q.b), .u8_o(b8));

`ifdef PIXEL_WRITER_ACCUM_EN
    logic [7:0]  blend_shift;
    logic [23:0] blend_rgb;

    // Moves a stored byte toward the new sample by 1/2^s of their difference.
    function automatic logic [7:0] blend8(input logic [7:0] old_v, input logic [7:0] new_v,
                                          input logic [7:0] s);
        logic signed [8:0] diff;
        diff = $signed({1'b0, new_v}) - $signed({1'b0, old_v});
        diff = diff >>> s;
        return old_v + diff[7:0];
    endfunction

    // Blend weight grows with completed frames, capped at MAX_SHIFT.
    always_comb begin
        blend_shift = (count_q > 8'(MAX_SHIFT)) ? 8'(MAX_SHIFT) : count_q;
        blend_rgb   = {blend8(fb_rdata[23:16], r8, blend_shift),
                       blend8(fb_rdata[15:8],  g8, blend_shift),
                       blend8(fb_rdata[7:0],   b8, blend_shift)};
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{fb_rdata, 32'(MAX_SHIFT)};
`endif

    // Next-state, write data, strobe and frame tracking.
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (ray_done) state_d = ST_CONV;
            end
`ifdef PIXEL_WRITER_ACCUM_EN
            ST_CONV:  state_d = ST_RD0;
            ST_RD0:   state_d = ST_RD1;
            ST_RD1:   state_d = ST_BLEND;
            ST_BLEND: begin
                state_d = ST_WRITE;
                if (in_range_q) wdata_d = blend_rgb;
            end
`else
            ST_CONV: begin
                state_d = ST_WRITE;
                if (in_range_q) wdata_d = {r8, g8, b8};
            end
`endif
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (in_range_q && (addr_q == LAST_ADDR)) begin
                    done_d = 1'b1;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        we_d = (state_d == ST_WRITE) && in_range_q;
    end

    // State and output registers; address is registered on acceptance so it is
    // already on the bus during CONV for the accumulation read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            color_q    <= '0;
            in_range_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ready_q <= (state_d == ST_IDLE);
            done_q  <= done_d;
            count_q <= count_d;
            if (accept) begin
                color_q    <= pixel_color;
                in_range_q <= in_range_in;
                addr_q     <= addr_in;
            end
        end
    end

    assign in_ready    = ready_q;
    assign fb_addr     = addr_q;
    assign fb_wdata    = wdata_q;
    assign fb_we       = we_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed self-checking bench for pixel_writer (either build of PIXEL_WRITER_ACCUM_EN).
module tb_pixel_writer;
    import pixel_writer_pkg::*;

`ifdef PIXEL_WRITER_ACCUM_EN
    localparam int WE_LAT = 5;
`else
    localparam int WE_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ray_done;
    logic [71:0] pixel_color;
    logic [10:0] pixel_h_in;
    logic [9:0]  pixel_v_in;
    logic        in_ready;
    logic [19:0] fb_addr;
    logic [23:0] fb_wdata;
    logic        fb_we;
    logic [23:0] fb_rdata;
    logic        frame_done;
    logic [7:0]  frame_count;

    int checks = 0;
    int errors = 0;

    pixel_writer dut (
        .clk        (clk),
        .rst        (rst),
        .ray_done   (ray_done),
        .pixel_color(pixel_color),
        .pixel_h_in (pixel_h_in),
        .pixel_v_in (pixel_v_in),
        .in_ready   (in_ready),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_we      (fb_we),
        .fb_rdata   (fb_rdata),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Pulse ray_done for one cycle once the block is ready; returns mid-cycle N+1.
    task automatic issue(input logic [71:0] c, input logic [10:0] h, input logic [9:0] v);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout got=%b want=1", in_ready);
        end
        pixel_color = c;
        pixel_h_in  = h;
        pixel_v_in  = v;
        ray_done    = 1'b1;
        @(negedge clk);
        ray_done    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b1)        begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        if (fb_we !== 1'b0)           begin errors++; $display("FAIL rst_fb_we got=%b want=0", fb_we); end
        if (fb_addr !== 20'd0)        begin errors++; $display("FAIL rst_fb_addr got=%0d want=0", fb_addr); end
        if (fb_wdata !== 24'd0)       begin errors++; $display("FAIL rst_fb_wdata got=%h want=0", fb_wdata); end
        if (frame_done !== 1'b0)      begin errors++; $display("FAIL rst_frame_done got=%b want=0", frame_done); end
        if (frame_count !== 8'd0)     begin errors++; $display("FAIL rst_frame_count got=%0d want=0", frame_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        issue({24'h3f0000, 24'h3e0000, 24'h000000}, 11'd3, 10'd2);
        for (int k = 1; k <= WE_LAT + 1; k++) begin
            checks++;
            if (fb_we !== (k == WE_LAT)) begin errors++; $display("FAIL basic_we k=%0d got=%b want=%b", k, fb_we, k == WE_LAT); end
            if (k == 1) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b want=0", in_ready); end
            end
            if (k == WE_LAT) begin
                checks += 2;
                if (fb_addr !== 20'd2563)      begin errors++; $display("FAIL basic_addr got=%0d want=2563", fb_addr); end
                if (fb_wdata !== 24'hFF8000)   begin errors++; $display("FAIL basic_wdata got=%h want=ff8000", fb_wdata); end
            end
            if (k == WE_LAT + 1) begin
                checks += 2;
                if (in_ready !== 1'b1)   begin errors++; $display("FAIL basic_ready got=%b want=1", in_ready); end
                if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_done got=%b want=0", frame_done); end
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_channels();
        logic [71:0] col [2];
        logic [23:0] exp_w [2];
        col[0] = {24'hbf0000, 24'h400000, 24'h3d8000}; exp_w[0] = 24'h00FF60;
        col[1] = {24'h360000, 24'h370000, 24'h3effff}; exp_w[1] = 24'h0001FF;
        for (int i = 0; i < 2; i++) begin
            issue(col[i], 11'(10 + i), 10'd1);
            repeat (WE_LAT - 1) @(negedge clk);
            checks += 3;
            if (fb_we !== 1'b1)          begin errors++; $display("FAIL chan%0d_we got=%b want=1", i, fb_we); end
            if (fb_wdata !== exp_w[i])   begin errors++; $display("FAIL chan%0d_wdata got=%h want=%h", i, fb_wdata, exp_w[i]); end
            if (fb_addr !== 20'(1290 + i)) begin errors++; $display("FAIL chan%0d_addr got=%0d want=%0d", i, fb_addr, 1290 + i); end
            @(negedge clk);
        end
    endtask

    task automatic test_out_of_range();
        logic [10:0] hh [2];
        logic [9:0]  vv [2];
        hh[0] = 11'd1280; vv[0] = 10'd0;
        hh[1] = 11'd0;    vv[1] = 10'd720;
        for (int i = 0; i < 2; i++) begin
            issue({24'h3f0000, 24'h3f0000, 24'h3f0000}, hh[i], vv[i]);
            for (int k = 1; k <= WE_LAT + 1; k++) begin
                checks++;
                if (fb_we !== 1'b0) begin errors++; $display("FAIL oor%0d_we k=%0d got=%b want=0", i, k, fb_we); end
                if (k == WE_LAT + 1) begin
                    checks += 2;
                    if (in_ready !== 1'b1)   begin errors++; $display("FAIL oor%0d_ready got=%b want=1", i, in_ready); end
                    if (frame_done !== 1'b0) begin errors++; $display("FAIL oor%0d_done got=%b want=0", i, frame_done); end
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_frame();
        issue({24'h3f0000, 24'h000000, 24'h3f0000}, 11'd1279, 10'd719);
        repeat (WE_LAT - 1) @(negedge clk);
        checks += 3;
        if (fb_we !== 1'b1)          begin errors++; $display("FAIL frame_we got=%b want=1", fb_we); end
        if (fb_addr !== 20'd921599)  begin errors++; $display("FAIL frame_addr got=%0d want=921599", fb_addr); end
        if (frame_done !== 1'b0)     begin errors++; $display("FAIL frame_done_early got=%b want=0", frame_done); end
        @(negedge clk);
        checks += 2;
        if (frame_done !== 1'b1)     begin errors++; $display("FAIL frame_done got=%b want=1", frame_done); end
        if (frame_count !== 8'd1)    begin errors++; $display("FAIL frame_count got=%0d want=1", frame_count); end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0)     begin errors++; $display("FAIL frame_done_pulse got=%b want=0", frame_done); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            issue({24'h3e0000, 24'h3e0000, 24'h3e0000}, 11'd1279, 10'd719);
            repeat (WE_LAT) @(negedge clk);
            if (i == 99) begin
                checks++;
                if (frame_count !== 8'd101) begin errors++; $display("FAIL sat_mid got=%0d want=101", frame_count); end
            end
        end
        checks += 2;
        if (frame_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d want=255", frame_count); end
        if (frame_done !== 1'b1)    begin errors++; $display("FAIL sat_done got=%b want=1", frame_done); end
    endtask

    task automatic test_reset_abort();
        issue({24'h3f0000, 24'h3f0000, 24'h3f0000}, 11'd7, 10'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (fb_we !== 1'b0)       begin errors++; $display("FAIL abort_we got=%b want=0", fb_we); end
        if (in_ready !== 1'b1)    begin errors++; $display("FAIL abort_ready got=%b want=1", in_ready); end
        if (frame_count !== 8'd0) begin errors++; $display("FAIL abort_count got=%0d want=0", frame_count); end
        for (int k = 0; k < WE_LAT + 1; k++) begin
            @(negedge clk);
            checks++;
            if (fb_we !== 1'b0) begin errors++; $display("FAIL abort_we_late k=%0d got=%b want=0", k, fb_we); end
        end
    endtask

`ifdef PIXEL_WRITER_ACCUM_EN
    task automatic test_accum();
        for (int i = 0; i < 2; i++) begin
            issue({24'h000000, 24'h000000, 24'h000000}, 11'd1279, 10'd719);
            repeat (WE_LAT) @(negedge clk);
        end
        checks++;
        if (frame_count !== 8'd2) begin errors++; $display("FAIL accum_count got=%0d want=2", frame_count); end
        fb_rdata = 24'h000000;
        issue({24'h3f0000, 24'h000000, 24'h000000}, 11'd5, 10'd5);
        checks++;
        if (fb_addr !== 20'd6405) begin errors++; $display("FAIL accum_rd_addr got=%0d want=6405", fb_addr); end
        repeat (WE_LAT - 1) @(negedge clk);
        checks += 2;
        if (fb_we !== 1'b1)         begin errors++; $display("FAIL accum_we got=%b want=1", fb_we); end
        if (fb_wdata !== 24'h3F0000) begin errors++; $display("FAIL accum_wdata got=%h want=3f0000", fb_wdata); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL accum_ready got=%b want=1", in_ready); end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        ray_done    = 1'b0;
        pixel_color = '0;
        pixel_h_in  = '0;
        pixel_v_in  = '0;
        fb_rdata    = '0;
        test_reset();
        test_basic();
        test_channels();
        test_out_of_range();
        test_frame();
        test_saturate();
        test_reset_abort();
`ifdef PIXEL_WRITER_ACCUM_EN
        test_accum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Downstream stage of the ray tracer core. Captures each finished ray's fp24 colour and pixel coordinates on the `ray_done` pulse and converts each channel to clamped 8-bit unsigned. Writes the resulting RGB888 word to the framebuffer BRAM port and tracks frame completion. Optionally blends the new sample with the stored pixel for progressive accumulation across frames.

## Interface
Parameters:
- `WIDTH`, 1280, pixels per line
- `HEIGHT`, 720, lines per frame
- `MAX_SHIFT`, 4, max blend shift (accumulation only)
- `ADDR_W`, `$clog2(WIDTH*HEIGHT)`, framebuffer address width

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `ray_done` in 1: one-cycle pulse, result valid
- `pixel_color` in fp24_vec3: {r,g,b}, r in [71:48]
- `pixel_h_in` in 11: pixel column
- `pixel_v_in` in 10: pixel row
- `in_ready` out 1: block can accept `ray_done`
- `fb_addr` out ADDR_W: read/write address
- `fb_wdata` out 24: {r8,g8,b8}
- `fb_we` out 1: write strobe
- `fb_rdata` in 24: BRAM read data, 2-cycle latency (used only with accumulation)
- `frame_done` out 1: one-cycle pulse after pixel (WIDTH-1, HEIGHT-1) is written
- `frame_count` out 8: completed frames, saturates at 255

## Operation
- fp24 layout is {sign[23], exp[22:16], mant[15:0]}, bias 63; 0x3f0000 = 1.0.
- Channel to byte, truncating:
  - sign=1 → 0
  - exp≥63 → 255
  - exp<55 → 0
  - otherwise `{1'b1, mant[15:9]} >> (62-exp)`
- Address: `v*WIDTH + h`, computed in CONV.
- Out-of-range input (`h≥WIDTH` or `v≥HEIGHT`):
  - no write, no `frame_done`
  - FSM returns to IDLE on the normal schedule
- FSM without accumulation: IDLE → CONV → WRITE → IDLE.
- FSM with accumulation: IDLE → CONV → RD0 → RD1 → BLEND → WRITE → IDLE.
  - CONV drives `fb_addr` for the read.
  - BLEND computes, per channel, `new8` = the byte converted from the new sample:
    - `out = old + ((new8 - old) >>> s)`, signed 9-bit difference
    - `s = min(frame_count, MAX_SHIFT)`
    - `frame_count=0` therefore overwrites the stored pixel
- Input capture:
  - `in_ready` = (state==IDLE).
  - `ray_done` is sampled only in IDLE. The colour and coordinates are latched the same cycle.
  - `ray_done` while not ready is ignored. The upstream tracer spends many cycles per ray, so this cannot occur in normal use.
- WRITE:
  - `fb_we=1` for exactly one cycle.
  - `fb_addr`/`fb_wdata` are valid that cycle.
- Last pixel: if the written address is `WIDTH*HEIGHT-1`, then on the cycle after the write:
  - `frame_done` pulses
  - `frame_count` increments (saturating)
- Reset values: state IDLE, `in_ready` 1, `fb_we` 0, `fb_addr` 0, `fb_wdata` 0, `frame_done` 0, `frame_count` 0.
- Reset mid-operation aborts the transaction; no write is issued after reset is asserted.

## Timing
- `ray_done` accepted at cycle N (no accumulation):
  - CONV N+1
  - `fb_we` N+2
  - `in_ready` high again N+3
  - `frame_done` N+3
- With accumulation:
  - read address on the bus at N+1
  - `fb_rdata` sampled in BLEND at N+4
  - `fb_we` at N+5
  - `in_ready` at N+6
- Throughput: one sample per 3 cycles (6 with accumulation).
- `fb_addr` holds its last value between transactions.

## Configuration
- `PIXEL_WRITER_ACCUM_EN` defined:
  - read-modify-write blend path, RD0/RD1/BLEND states
  - `fb_rdata` used
- Undefined:
  - direct overwrite, 3-state FSM
  - `fb_rdata` ignored
  - `MAX_SHIFT` unused
  - `frame_count` still maintained

## Structure
- Shared package: `fp24`/`fp24_vec3` typedefs (existing), fp24 field widths, `FP24_BIAS=63`.
- Sub-module `fp24_to_u8`: purely combinational, one channel. Instantiate three times.
- FSM, address multiply and blend stay in `pixel_writer`.

## Test plan
- `pixel_color`={0x3f0000, 0x3e0000, 0x000000}, h=3, v=2, ray_done at N → `fb_we` at N+2, `fb_addr`=2563, `fb_wdata`=0xFF8000.
- Channel 0xbf0000 (−1.0), 0x400000 (2.0), 0x3d8000 (0.375) → bytes 0x00, 0xFF, 0x60.
- h=1280, v=0 → no `fb_we` for 3 cycles; `in_ready` high at N+3.
- Pixel (1279,719) written → `fb_addr`=921599, `frame_done` one pulse, `frame_count` 0→1. Repeat 300 frames → `frame_count` stays 255.
- ACCUM, `frame_count`=2, stored 0x000000, new r=1.0 → `fb_wdata`=0x3F0000 at N+5 (255>>>2=63).
- `rst` asserted at N+1 after an accepted `ray_done` → no `fb_we`; next cycle `in_ready`=1 and `frame_count`=0.
